// File: rtl/gg_vlc_block_pack.sv
// CAVLC residual-block bitstream writer: packs coded symbols MSB-first
// into a left-justified window tagged with a one-hot end marker.
module gg_vlc_block_pack #(
  parameter int WIDTH  = 48,
  parameter int CODE_W = 32,
  parameter int LEN_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sym_valid,
  output logic              sym_ready,
  input  logic [CODE_W-1:0] sym_code,
  input  logic [LEN_W-1:0]  sym_len,
  input  logic              sym_last,
  input  logic [4:0]        sym_nc_idx,
  input  logic              sym_ac_flag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_bits,
  output logic [WIDTH-1:0]  out_end,
  output logic [LEN_W-1:0]  out_len,
  output logic [4:0]        out_nc_idx,
  output logic              out_ac_flag,
  output logic              out_err
);

  typedef enum logic {ACCUM, HOLD} state_t;

  localparam logic [LEN_W:0] LP_WIDTH = (LEN_W+1)'(WIDTH);
  localparam logic [LEN_W:0] LP_MAX   = (LEN_W+1)'(WIDTH-1);
  localparam logic [LEN_W:0] LP_CODE  = (LEN_W+1)'(CODE_W);
  localparam logic [WIDTH-1:0] LP_TOP = {1'b1, {(WIDTH-1){1'b0}}};

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0]  r_window;
  logic [LEN_W-1:0]  r_pos;
  logic              r_err;
  logic              r_started;
  logic [4:0]        r_nc_idx;
  logic              r_ac_flag;

  logic [CODE_W-1:0] w_mask;
  logic [CODE_W-1:0] w_code;
  logic [LEN_W:0]    w_sum;
  logic [LEN_W:0]    w_shamt;
  logic [WIDTH-1:0]  w_ins;
  logic              w_bad;
  logic              w_acc;
  logic              w_rel;

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < CODE_W; i++)
      w_mask[i] = ({1'b0, sym_len} > (LEN_W+1)'(i));
  end

  assign w_code  = sym_code & w_mask;
  assign w_sum   = {1'b0, r_pos} + {1'b0, sym_len};
  assign w_bad   = ({1'b0, sym_len} > LP_CODE) || (w_sum > LP_MAX);
  // code LSB lands at WIDTH-pos-len; never negative once w_bad is clear
  assign w_shamt = LP_WIDTH - w_sum;
  assign w_ins   = {{(WIDTH-CODE_W){1'b0}}, w_code} << w_shamt;

  assign w_acc = sym_valid & sym_ready;
  assign w_rel = out_valid & out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ACCUM;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    sym_ready = 1'b0;
    out_valid = 1'b0;
    unique case (r_state)
      ACCUM: begin
        sym_ready = 1'b1;
        if (sym_valid && sym_last) w_next = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) w_next = ACCUM;
      end
      default: w_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_window  <= '0;
      r_pos     <= '0;
      r_err     <= 1'b0;
      r_started <= 1'b0;
      r_nc_idx  <= '0;
      r_ac_flag <= 1'b0;
    end else if (w_rel) begin
      r_window  <= '0;
      r_pos     <= '0;
      r_err     <= 1'b0;
      r_started <= 1'b0;
    end else if (w_acc) begin
      r_started <= 1'b1;
      if (!r_started) begin
        r_nc_idx  <= sym_nc_idx;
        r_ac_flag <= sym_ac_flag;
      end
      if (w_bad) begin
        r_err <= 1'b1;
      end else begin
        r_window <= r_window | w_ins;
        r_pos    <= w_sum[LEN_W-1:0];
      end
    end
  end

  assign out_bits    = r_window;
  assign out_end     = LP_TOP >> r_pos;
  assign out_len     = r_pos;
  assign out_nc_idx  = r_nc_idx;
  assign out_ac_flag = r_ac_flag;
  assign out_err     = r_err;

endmodule

// File: doc/gg_vlc_block_pack.md
Name: gg_vlc_block_pack

Overview:
- Residual-block bitstream writer; the counterpart of gg_parse_lattice.
- Accepts a stream of already-coded CAVLC symbols (coeff_token, trailing-one signs, levels, total_zeros, run_before) for one 4x4 block.
- Packs them MSB-first into a left-justified WIDTH-bit window.
- Emits the window with a one-hot block-end marker and the block's nc_idx/ac_flag, in exactly the bits/end_bits form the lattice consumes.
- Used as the encoder-side block assembler and as a self-checking stimulus source for the lattice.

Parameters:
- WIDTH, 48: output window width in bits; maximum block length is WIDTH-1.
- CODE_W, 32: maximum symbol code width.
- LEN_W, 6: width of the length fields; must satisfy 2^LEN_W > max(WIDTH-1, CODE_W).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- sym_valid  in  1  symbol offered
- sym_ready  out  1  symbol accepted when sym_valid & sym_ready
- sym_code  in  CODE_W  code value, right-justified; bits at or above sym_len ignored
- sym_len  in  LEN_W  code length, 0..CODE_W
- sym_last  in  1  final symbol of the block
- sym_nc_idx  in  5  one-hot coeff_token table select: [3:0] luma nC class, [4] chroma DC; captured on first symbol of block
- sym_ac_flag  in  1  AC block (max 15 coeffs); captured on first symbol of block
- out_valid  out  1  packed block available
- out_ready  in  1  consumer takes block when out_valid & out_ready
- out_bits  out  WIDTH  packed bits; first coded bit at [WIDTH-1], zero below the block
- out_end  out  WIDTH  one-hot; bit [WIDTH-1-out_len] set
- out_len  out  LEN_W  total block length in bits
- out_nc_idx  out  5  captured nc_idx
- out_ac_flag  out  1  captured ac_flag
- out_err  out  1  overflow or illegal length seen in this block

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high (reset).
- Reset state: FSM in ACCUM; window, pos, out_len, out_nc_idx, out_ac_flag and out_err all 0. out_valid=0; sym_ready=1 one cycle after reset deasserts. A reset mid-block or mid-hold discards all partial or held data.
- State ACCUM:
  - sym_ready=1, out_valid=0.
  - On handshake: mask sym_code to sym_len bits, OR it into window at bits [WIDTH-1-pos -: sym_len], then pos += sym_len.
  - First symbol of a block (pos==0 and no symbol yet accepted) latches nc_idx and ac_flag.
  - sym_len==0 is legal and adds no bits.
- Overflow and illegal length:
  - Trigger: pos+sym_len > WIDTH-1, or sym_len > CODE_W.
  - Response: the symbol's bits are dropped, pos is unchanged, err is set (sticky per block). The handshake still completes and sym_last is still honoured.
- Transition ACCUM to HOLD: on an accepted symbol with sym_last=1. out_valid rises the next cycle; latency is 1 cycle from the last symbol.
- State HOLD:
  - sym_ready=0, out_valid=1.
  - All out_* are registered and stable until the handshake.
  - out_end = 1 << (WIDTH-1-pos); out_len = pos.
- Transition HOLD to ACCUM: on out_ready. Window, pos and err clear; sym_ready returns to 1 the next cycle. A sym_valid held during HOLD is not consumed.
- Throughput: n-symbol block takes n+1 cycles minimum; no overlap of consecutive blocks.
- out_bits/out_end/out_len/out_nc_idx/out_ac_flag/out_err are don't-care while out_valid=0 but must not be X after reset.

Test Plan:
- Luma block: nc_idx=5'b00001, five symbols (8'b00000111, len8), (10'b0000000001, len10), (8'b00000101, len8), (3'b110, len3), (1'b0, len1, last).
  - out_len=30; out_bits[47:18]=30'b00000111_0000000001_00000101_110_0, [17:0]=0.
  - out_end=48'h0000_0002_0000; out_nc_idx=5'b00001; out_valid 1 cycle after last.
- Chroma DC: one symbol code=1, len=1, last, nc_idx=5'b10000, ac_flag=1.
  - out_bits=48'h8000_0000_0000, out_end=48'h4000_0000_0000, out_len=1, out_ac_flag=1.
- Empty block: sym_len=0, last.
  - out_bits=0, out_end=48'h8000_0000_0000, out_len=0, out_err=0.
- Masking and overflow:
  - Block A: sym_code=32'hFFFF_FFFF, len=3, last → out_bits=48'hE000_0000_0000, out_len=3.
  - Block B: two symbols of len 32, second last → out_err=1, out_len=32, second symbol absent from out_bits. Next block has out_err=0.
- Backpressure: hold out_ready=0 for 4 cycles with sym_valid=1 presented.
  - Outputs stable; sym_ready=0; no symbol consumed.
  - On out_ready=1, the pending symbol is accepted the following cycle.
- Reset mid-block: accept 2 symbols, pulse reset asynchronously (between clock edges).
  - sym_ready=1, out_valid=0 immediately after.
  - Next full block matches standalone expected output (no stale bits).
